tk1_spi_target: RTL

//  SPI responder (target) for the peer end of the tk1 SPI initiator: mode 0, MSB first, 8-bit frames.

---
 rtl/tk1_spi_target_pkg.sv | 30 +++
 rtl/tk1_spi_target_if.sv | 12 +
 rtl/tk1_spi_target_sync.sv | 31 +++
 rtl/tk1_spi_target.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tk1_spi_target_pkg.sv
// Shared definitions for the tk1 SPI target: register map, STATUS layout and FSM states.
package tk1_spi_target_pkg;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_RX_DATA = 8'h01;
    localparam logic [7:0] ADDR_TX_DATA = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_SELECTED = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic logic [31:0] status_word(input logic selected, input logic overrun,
                                                input logic tx_empty, input logic rx_valid);
        logic [31:0] w;
        w = 32'h0;
        w[STAT_SELECTED] = selected;
        w[STAT_OVERRUN]  = overrun;
        w[STAT_TX_EMPTY] = tx_empty;
        w[STAT_RX_VALID] = rx_valid;
        return w;
    endfunction

endpackage

// File: rtl/tk1_spi_target_if.sv
// Core bus (8-bit word address, 32-bit data, zero wait states) between firmware and the SPI target.
interface tk1_spi_target_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, we, address, write_data, input read_data, ready);
    modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/tk1_spi_target_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a history flop for edge strobes.
module tk1_spi_target_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/tk1_spi_target.sv
// SPI mode-0 target (MSB first, 8-bit frames) with a polled core-bus register interface.
module tk1_spi_target
    import tk1_spi_target_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hff
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spi_clk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             rx_irq,
    tk1_spi_target_if.slave  bus
);

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic cs_fall, cs_rise, cs_n_lvl;
    logic mosi_s, mosi_rise, mosi_fall;

    tk1_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .async_i(spi_clk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

    tk1_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .async_i(spi_cs_n),
        .level_o(cs_n_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

    tk1_spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .async_i(spi_mosi),
        .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

    logic unused_sigs;
    assign unused_sigs = sclk_lvl ^ cs_n_lvl ^ mosi_rise ^ mosi_fall ^ (^bus.write_data[31:8]);

    state_e     state_q, state_d;
    logic [2:0] bit_ctr_q, bit_ctr_d;
    logic [7:0] shift_in_q, shift_in_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic [7:0] rx_reg_q, rx_reg_d;
    logic [7:0] tx_reg_q, tx_reg_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       tx_empty_q, tx_empty_d;
    logic       byte_done_q, byte_done_d;
    logic       rx_irq_q;

    logic rd_en, wr_en, rd_rx, wr_tx, wr_ctrl;
    logic load, complete;
    logic selected;

    assign rd_en   = bus.cs & ~bus.we;
    assign wr_en   = bus.cs & bus.we;
    assign rd_rx   = rd_en && (bus.address == ADDR_RX_DATA);
    assign wr_tx   = wr_en && (bus.address == ADDR_TX_DATA);
    assign wr_ctrl = wr_en && (bus.address == ADDR_CTRL);

    assign selected  = (state_q == ST_ACTIVE);
    assign bus.ready = bus.cs;
    assign spi_miso  = selected ? shift_out_q[7] : 1'b1;
    assign rx_irq    = rx_irq_q;

    always_comb begin
        bus.read_data = 32'h0;
        if (rd_en) begin
            case (bus.address)
                ADDR_STATUS:  bus.read_data = status_word(selected, overrun_q, tx_empty_q, rx_valid_q);
                ADDR_RX_DATA: bus.read_data = {24'h0, rx_reg_q};
                default:      bus.read_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_ctr_d   = bit_ctr_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        rx_reg_d    = rx_reg_q;
        tx_reg_d    = tx_reg_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        tx_empty_d  = tx_empty_q;
        byte_done_d = byte_done_q;
        load        = 1'b0;
        complete    = 1'b0;

        // cs_rise is checked first so a deselect beats a coincident clock edge
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_ctr_d = 3'd0;
                    load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    bit_ctr_d   = 3'd0;
                    byte_done_d = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        shift_in_d = {shift_in_q[6:0], mosi_s};
                        bit_ctr_d  = bit_ctr_q + 3'd1;
                        if (bit_ctr_q == 3'd7) begin
                            complete    = 1'b1;
                            rx_reg_d    = {shift_in_q[6:0], mosi_s};
                            byte_done_d = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        if (byte_done_q) begin
                            load        = 1'b1;
                            byte_done_d = 1'b0;
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b1};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) shift_out_d = tx_empty_q ? FILL_BYTE : tx_reg_q;

        // A firmware write overrides the "consumed" flag of a coincident reload
        if (wr_tx) begin
            tx_reg_d   = bus.write_data[7:0];
            tx_empty_d = 1'b0;
        end else if (load) begin
            tx_empty_d = 1'b1;
        end

        if (complete)   rx_valid_d = 1'b1;
        else if (rd_rx) rx_valid_d = 1'b0;

        if (complete && rx_valid_q && !rd_rx)       overrun_d = 1'b1;
        else if (wr_ctrl && bus.write_data[0])      overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_ctr_q   <= 3'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= FILL_BYTE;
            rx_reg_q    <= 8'h00;
            tx_reg_q    <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_empty_q  <= 1'b1;
            byte_done_q <= 1'b0;
            rx_irq_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_ctr_q   <= bit_ctr_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            rx_reg_q    <= rx_reg_d;
            tx_reg_q    <= tx_reg_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            tx_empty_q  <= tx_empty_d;
            byte_done_q <= byte_done_d;
            rx_irq_q    <= rx_valid_q;
        end
    end

endmodule
